// File: rtl/led_pattern_player_pkg.sv
// Shared definitions for the LED pattern player and anything else that
// speaks its mode encoding (debouncer-side logic, benches).
//   - MODE_* : bit index of each mode in the one-hot mode word
//   - LEDS_* : common LED drive words
//   - mode_e : FSM state type, one state per mode
//   - decode_mode() : one-hot mode word -> {valid, mode}
package led_pattern_player_pkg;

    localparam int MODE_SOLID   = 0;
    localparam int MODE_BLINK   = 1;
    localparam int MODE_SCAN    = 2;
    localparam int MODE_BREATHE = 3;

    localparam logic [3:0] LEDS_ALL_ON = 4'b1111;
    localparam logic [3:0] LEDS_OFF    = 4'b0000;

    typedef enum logic [1:0] {
        ST_SOLID   = 2'(MODE_SOLID),
        ST_BLINK   = 2'(MODE_BLINK),
        ST_SCAN    = 2'(MODE_SCAN),
        ST_BREATHE = 2'(MODE_BREATHE)
    } mode_e;

    typedef struct packed {
        logic  valid;
        mode_e idx;
    } mode_dec_t;

    // Anything that is not exactly one bit set is reported as invalid.
    function automatic mode_dec_t decode_mode(input logic [3:0] code);
        mode_dec_t d;
        d.valid = 1'b1;
        d.idx   = ST_SOLID;
        case (code)
            4'b0001: d.idx = ST_SOLID;
            4'b0010: d.idx = ST_BLINK;
            4'b0100: d.idx = ST_SCAN;
            4'b1000: d.idx = ST_BREATHE;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/led_pattern_player_tick_prescaler.sv
// tick_prescaler: free-running divide-by-DIV tick generator.
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   clear   in  restart the count at 0 (wins over the wrap)
//   tick    out high for the single cycle where count == DIV-1
module tick_prescaler #(
    parameter int DIV = 1_200_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_player.sv
// led_pattern_player: drives 4 board LEDs with a pattern chosen by the
// debounced one-hot mode word (solid, blink, bouncing scan, PWM breathe).
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   mode_onehot  in   [3:0] mode request, bit k = mode k
//   leds         out  [3:0] registered LED drive, 1 = lit
//   mode_err     out  one-cycle pulse when the sampled mode word was not one-hot
// Pipeline: mode_onehot -> mode_reg -> (mode_idx, step state, leds, mode_err).
module led_pattern_player
    import led_pattern_player_pkg::*;
#(
    parameter int TICK_DIV     = 1_200_000,
    parameter int PWM_BITS     = 8,
    parameter int BREATHE_STEP = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] mode_onehot,
    output logic [3:0] leds,
    output logic       mode_err
);

    localparam logic [3:0]        MODE_RESET_CODE = 4'b0001 << MODE_SOLID;
    localparam logic [PWM_BITS:0] DUTY_MAX_W = (PWM_BITS+1)'((2 ** PWM_BITS) - 1);
    localparam logic [PWM_BITS:0] STEP_W     = (PWM_BITS+1)'(BREATHE_STEP);

    logic [3:0]          mode_reg;
    mode_dec_t           dec;
    mode_e               mode_idx, mode_idx_next;
    logic                change, tick;

    logic                blink_on, blink_on_next;
    logic [1:0]          scan_pos, scan_pos_next;
    logic                scan_up, scan_up_next;
    logic [PWM_BITS-1:0] duty, duty_next;
    logic                duty_up, duty_up_next;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_next;
    logic [PWM_BITS:0]   duty_sum;
    logic [3:0]          leds_next;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (change),
        .tick    (tick)
    );

    assign dec = decode_mode(mode_reg);

    // Input stage: reset to the mode-0 code so release raises no error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg <= MODE_RESET_CODE;
        end else begin
            mode_reg <= mode_onehot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_idx <= ST_SOLID;
            blink_on <= 1'b1;
            scan_pos <= 2'd0;
            scan_up  <= 1'b1;
            duty     <= '0;
            duty_up  <= 1'b1;
            pwm_cnt  <= '0;
            leds     <= LEDS_OFF;
            mode_err <= 1'b0;
        end else begin
            mode_idx <= mode_idx_next;
            blink_on <= blink_on_next;
            scan_pos <= scan_pos_next;
            scan_up  <= scan_up_next;
            duty     <= duty_next;
            duty_up  <= duty_up_next;
            pwm_cnt  <= pwm_cnt_next;
            leds     <= leds_next;
            mode_err <= !dec.valid;
        end
    end

    // Extra bit keeps duty+STEP from wrapping before the saturation test.
    assign duty_sum = {1'b0, duty} + STEP_W;

    // NOTE: every output of this block is given a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        mode_idx_next = dec.valid ? dec.idx : mode_idx;
        change        = (mode_idx_next != mode_idx);
        blink_on_next = blink_on;
        scan_pos_next = scan_pos;
        scan_up_next  = scan_up;
        duty_next     = duty;
        duty_up_next  = duty_up;
        pwm_cnt_next  = pwm_cnt + PWM_BITS'(1);
        leds_next     = LEDS_OFF;

        // A mode change restarts the pattern and swallows a coincident tick.
        if (change) begin
            blink_on_next = 1'b1;
            scan_pos_next = 2'd0;
            scan_up_next  = 1'b1;
            duty_next     = '0;
            duty_up_next  = 1'b1;
        end else if (tick) begin
            case (mode_idx)
                ST_BLINK: blink_on_next = !blink_on;
                ST_SCAN: begin
                    // Turn around at the ends so each end is shown once.
                    if (scan_up) begin
                        if (scan_pos == 2'd3) begin
                            scan_pos_next = 2'd2;
                            scan_up_next  = 1'b0;
                        end else begin
                            scan_pos_next = scan_pos + 2'd1;
                        end
                    end else begin
                        if (scan_pos == 2'd0) begin
                            scan_pos_next = 2'd1;
                            scan_up_next  = 1'b1;
                        end else begin
                            scan_pos_next = scan_pos - 2'd1;
                        end
                    end
                end
                ST_BREATHE: begin
                    if (duty_up) begin
                        if (duty_sum >= DUTY_MAX_W) begin
                            duty_next    = DUTY_MAX_W[PWM_BITS-1:0];
                            duty_up_next = 1'b0;
                        end else begin
                            duty_next = duty_sum[PWM_BITS-1:0];
                        end
                    end else begin
                        if ({1'b0, duty} <= STEP_W) begin
                            duty_next    = '0;
                            duty_up_next = 1'b1;
                        end else begin
                            duty_next = duty - STEP_W[PWM_BITS-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end

        // Decode from next-state values so the registered leds always match
        // the state registers after the same edge.
        case (mode_idx_next)
            ST_SOLID:   leds_next = LEDS_ALL_ON;
            ST_BLINK:   leds_next = blink_on_next ? LEDS_ALL_ON : LEDS_OFF;
            ST_SCAN:    leds_next = 4'b0001 << scan_pos_next;
            ST_BREATHE: leds_next = {4{pwm_cnt_next < duty_next}};
            default:    leds_next = LEDS_OFF;
        endcase
    end

endmodule

// File: tb/tb_led_pattern_player.sv
// Bench for led_pattern_player with TICK_DIV=4, PWM_BITS=4, BREATHE_STEP=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_led_pattern_player;
    import led_pattern_player_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [3:0] mode_onehot;
    logic [3:0] leds;
    logic       mode_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    typedef struct {
        logic [3:0] mode;
        int         wait_cyc;
        logic [3:0] leds;
        logic       err;
    } vec_t;

    vec_t vecs[28];
    int   duty_seq[10] = '{0, 4, 8, 12, 15, 11, 7, 3, 0, 4};

    led_pattern_player #(
        .TICK_DIV     (4),
        .PWM_BITS     (4),
        .BREATHE_STEP (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_onehot (mode_onehot),
        .leds        (leds),
        .mode_err    (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; its low bits track the free-running PWM counter.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        // Scan bounce from reset release, then restart, blink and illegal codes.
        vecs[0]  = '{4'b0100, 3, 4'b0001, 1'b0};
        vecs[1]  = '{4'b0100, 1, 4'b0010, 1'b0};
        vecs[2]  = '{4'b0100, 4, 4'b0100, 1'b0};
        vecs[3]  = '{4'b0100, 4, 4'b1000, 1'b0};
        vecs[4]  = '{4'b0100, 4, 4'b0100, 1'b0};
        vecs[5]  = '{4'b0100, 4, 4'b0010, 1'b0};
        vecs[6]  = '{4'b0100, 4, 4'b0001, 1'b0};
        vecs[7]  = '{4'b0100, 4, 4'b0010, 1'b0};
        vecs[8]  = '{4'b0100, 1, 4'b0010, 1'b0};
        vecs[9]  = '{4'b0001, 1, 4'b0010, 1'b0};
        vecs[10] = '{4'b0001, 1, LEDS_ALL_ON, 1'b0};
        vecs[11] = '{4'b0001, 3, LEDS_ALL_ON, 1'b0};
        vecs[12] = '{4'b0100, 1, LEDS_ALL_ON, 1'b0};
        vecs[13] = '{4'b0100, 1, 4'b0001, 1'b0};
        vecs[14] = '{4'b0100, 3, 4'b0001, 1'b0};
        vecs[15] = '{4'b0100, 1, 4'b0010, 1'b0};
        vecs[16] = '{4'b0010, 1, 4'b0010, 1'b0};
        vecs[17] = '{4'b0010, 1, LEDS_ALL_ON, 1'b0};
        vecs[18] = '{4'b0010, 3, LEDS_ALL_ON, 1'b0};
        vecs[19] = '{4'b0010, 1, LEDS_OFF, 1'b0};
        vecs[20] = '{4'b0010, 4, LEDS_ALL_ON, 1'b0};
        vecs[21] = '{4'b0000, 1, LEDS_ALL_ON, 1'b0};
        vecs[22] = '{4'b0010, 1, LEDS_ALL_ON, 1'b1};
        vecs[23] = '{4'b0110, 1, LEDS_ALL_ON, 1'b0};
        vecs[24] = '{4'b0010, 1, LEDS_OFF, 1'b1};
        vecs[25] = '{4'b0010, 1, LEDS_OFF, 1'b0};
        vecs[26] = '{4'b0010, 2, LEDS_OFF, 1'b0};
        vecs[27] = '{4'b0010, 1, LEDS_ALL_ON, 1'b0};

        reset_n     = 1'b0;
        mode_onehot = 4'b0100;
        repeat (3) @(negedge clk);
        check("reset_leds", leds, LEDS_OFF);
        check("reset_err", {3'b0, mode_err}, 4'b0);

        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("release_scan_start", leds, 4'b0001);

        foreach (vecs[i]) begin
            mode_onehot = vecs[i].mode;
            repeat (vecs[i].wait_cyc) @(negedge clk);
            check($sformatf("vec%0d_leds", i), leds, vecs[i].leds);
            check($sformatf("vec%0d_err", i), {3'b0, mode_err}, {3'b0, vecs[i].err});
        end

        // Breathe: duty steps every 4 cycles; leds lit while pwm count < duty.
        mode_onehot = 4'b1000;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 40; m++) begin
            check($sformatf("breathe_m%0d", m), leds,
                  ((cyc % 16) < duty_seq[m / 4]) ? LEDS_ALL_ON : LEDS_OFF);
            @(negedge clk);
        end

        // Reset mid-pattern: asynchronous clear, then restart from mode 0.
        mode_onehot = 4'b0001;
        repeat (2) @(negedge clk);
        check("pre_reset_solid", leds, LEDS_ALL_ON);
        reset_n = 1'b0;
        #1;
        check("async_reset_leds", leds, LEDS_OFF);
        check("async_reset_err", {3'b0, mode_err}, 4'b0);
        mode_onehot = 4'b1000;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rerelease_mode0", leds, LEDS_ALL_ON);
        @(negedge clk);
        check("rerelease_breathe", leds, LEDS_OFF);
        check("rerelease_err", {3'b0, mode_err}, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
